// File: rtl/waffle_result_capture.sv
// waffle_result_capture
// Sits after the waffle engine. It waits a fixed drain interval after the
// engine reports its last inputs, then captures the final maximum-subarray
// value and the elapsed cycle count. Both are offered on a valid/ready port,
// and done is held until the next run starts.
// Optional feature macro: WAFFLE_MONO_CHECK_EN adds a sticky error flag
// (mono_err) that is raised when the running maximum ever decreases.
module waffle_result_capture #(
    parameter int DATA_W       = 32,
    parameter int DRAIN_CYCLES = 4,
    parameter int CYC_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              last_inputs,
    input  logic [DATA_W-1:0] waffle_val,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [CYC_W-1:0]  res_cycles,
    output logic              busy,
    output logic              done,
    output logic              mono_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CYC_W-1:0] cyc_cnt;
    logic [CYC_W-1:0] cyc_inc;
    logic [7:0]       drain_cnt;
    logic             start_ok;
    logic             capture;

    // start only counts in IDLE and DONE; everywhere else it is ignored
    assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
    // the last DRAIN cycle is the one where the drain counter has reached zero
    assign capture  = (state == S_DRAIN) && (drain_cnt == 8'd0);
    // the cycle counter sticks at all-ones instead of wrapping
    assign cyc_inc  = (&cyc_cnt) ? cyc_cnt : cyc_cnt + CYC_W'(1);

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start)               state_nxt = S_RUN;
            S_RUN:     if (last_inputs)         state_nxt = S_DRAIN;
            S_DRAIN:   if (drain_cnt == 8'd0)   state_nxt = S_PRESENT;
            S_PRESENT: if (res_ready)           state_nxt = S_DONE;
            S_DONE:    if (start)               state_nxt = S_RUN;
            default:                            state_nxt = S_IDLE;
        endcase
    end

    // counters, result capture and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt    <= '0;
            drain_cnt  <= '0;
            res_data   <= '0;
            res_cycles <= '0;
            res_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (start_ok) begin
                cyc_cnt <= '0;
            end else if ((state == S_RUN) || (state == S_DRAIN)) begin
                cyc_cnt <= cyc_inc;
            end

            if ((state == S_RUN) && last_inputs) begin
                drain_cnt <= 8'(DRAIN_CYCLES - 1);
            end else if ((state == S_DRAIN) && (drain_cnt != 8'd0)) begin
                drain_cnt <= drain_cnt - 8'd1;
            end

            if (capture) begin
                res_data   <= waffle_val;
                res_cycles <= cyc_inc;
            end

            res_valid <= (state_nxt == S_PRESENT);
            busy      <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
            done      <= (state_nxt == S_DONE);
        end
    end

`ifdef WAFFLE_MONO_CHECK_EN
    logic [DATA_W-1:0] prev_val;
    logic              first_run;

    // track the previous running max and flag any decrease while the engine is active
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_val  <= '0;
            first_run <= 1'b0;
            mono_err  <= 1'b0;
        end else begin
            prev_val <= waffle_val;
            if (start_ok) begin
                first_run <= 1'b1;
                mono_err  <= 1'b0;
            end else begin
                first_run <= 1'b0;
                if ((((state == S_RUN) && !first_run) || (state == S_DRAIN)) &&
                    ($signed(waffle_val) < $signed(prev_val))) begin
                    mono_err <= 1'b1;
                end
            end
        end
    end
`else
    assign mono_err = 1'b0;
`endif

endmodule

// File: tb/tb_waffle_result_capture.sv
// Testbench for waffle_result_capture (default DRAIN_CYCLES=4).
// Expected results are queued when the stimulus that determines them is
// driven, and popped when the DUT raises res_valid.
module tb_waffle_result_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        last_inputs;
    logic [31:0] waffle_val;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [31:0] res_cycles;
    logic        busy;
    logic        done;
    logic        mono_err;

    typedef struct {
        logic [31:0] data;
        logic [31:0] cycles;
    } result_t;

    result_t sb[$];
    int      tests = 0;
    int      fails = 0;
    logic    mono_expect;

    waffle_result_capture #(
        .DATA_W(32),
        .DRAIN_CYCLES(4),
        .CYC_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .last_inputs(last_inputs),
        .waffle_val(waffle_val),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .res_cycles(res_cycles),
        .busy(busy),
        .done(done),
        .mono_err(mono_err)
    );

    // free-running clock
    always #5 clk = ~clk;

    // advance to the next cycle; outputs are settled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic l, input logic [31:0] v, input logic r);
        start       = s;
        last_inputs = l;
        waffle_val  = v;
        res_ready   = r;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // wait (bounded) for res_valid, then compare latency and the queued result
    task automatic collectResult(input string tag, input int exp_wait);
        result_t e;
        int      waited = 0;
        while (!res_valid && waited < 40) begin
            tick();
            waited++;
        end
        checkOutput({tag, "_latency"}, 64'(waited), 64'(exp_wait));
        if (res_valid) begin
            if (sb.size() == 0) begin
                checkOutput({tag, "_sb_nonempty"}, 64'(0), 64'(1));
            end else begin
                e = sb.pop_front();
                checkOutput({tag, "_data"}, 64'(res_data), 64'(e.data));
                checkOutput({tag, "_cycles"}, 64'(res_cycles), 64'(e.cycles));
            end
        end
    endtask

    initial begin
`ifdef WAFFLE_MONO_CHECK_EN
        mono_expect = 1'b1;
`else
        mono_expect = 1'b0;
`endif
        // reset
        rst = 1'b1;
        applyStimulus(0, 0, 32'h0, 0);
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst_valid", 64'(res_valid), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_done", 64'(done), 64'(0));
        checkOutput("rst_data", 64'(res_data), 64'(0));
        checkOutput("rst_cycles", 64'(res_cycles), 64'(0));
        checkOutput("rst_mono", 64'(mono_err), 64'(0));

        // basic run: start at cycle 0, last_inputs first sampled at cycle 20,
        // ignored start pulses in RUN (cycle 10) and DRAIN (cycle 22)
        applyStimulus(1, 0, 32'h50, 0);
        tick();
        for (int c = 1; c <= 24; c++) begin
            applyStimulus((c == 10) || (c == 22), c >= 20, 32'h50, 0);
            checkOutput("basic_busy", 64'(busy), 64'(1));
            checkOutput("basic_valid_low", 64'(res_valid), 64'(0));
            if (c == 20) sb.push_back('{data: 32'h50, cycles: 32'd24});
            tick();
        end
        applyStimulus(0, 1, 32'h99, 0);
        collectResult("basic", 0);
        checkOutput("basic_busy_off", 64'(busy), 64'(0));

        // backpressure: ready low for 7 cycles, waffle_val changes, start ignored
        for (int c = 0; c < 7; c++) begin
            applyStimulus(c == 3, 1, 32'h99, 0);
            checkOutput("bp_valid", 64'(res_valid), 64'(1));
            checkOutput("bp_data", 64'(res_data), 64'(32'h50));
            checkOutput("bp_cycles", 64'(res_cycles), 64'(24));
            tick();
        end
        applyStimulus(0, 1, 32'h99, 1);
        checkOutput("xfer_valid", 64'(res_valid), 64'(1));
        tick();
        applyStimulus(0, 0, 32'h99, 0);
        checkOutput("done_high", 64'(done), 64'(1));
        checkOutput("done_valid_low", 64'(res_valid), 64'(0));
        checkOutput("done_data_held", 64'(res_data), 64'(32'h50));
        tick();
        checkOutput("done_stays", 64'(done), 64'(1));

        // restart from DONE with a negative value, last_inputs in first RUN cycle,
        // last_inputs dropping in DRAIN and res_ready held high throughout
        applyStimulus(1, 0, 32'hFFFF_FFF6, 1);
        tick();
        checkOutput("restart_done_low", 64'(done), 64'(0));
        checkOutput("restart_busy", 64'(busy), 64'(1));
        applyStimulus(0, 1, 32'hFFFF_FFF6, 1);
        sb.push_back('{data: 32'hFFFF_FFF6, cycles: 32'd5});
        tick();
        applyStimulus(0, 0, 32'hFFFF_FFF6, 1);
        collectResult("neg", 4);
        tick();
        checkOutput("neg_done", 64'(done), 64'(1));
        checkOutput("neg_data_held", 64'(res_data), 64'(32'hFFFF_FFF6));

        // reset in the 2nd DRAIN cycle of a run whose last_inputs comes at cycle 10
        applyStimulus(1, 0, 32'h0, 0);
        tick();
        for (int c = 1; c <= 12; c++) begin
            applyStimulus(0, c >= 10, 32'h0, 0);
            if (c == 12) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        applyStimulus(0, 0, 32'h0, 0);
        checkOutput("mid_rst_busy", 64'(busy), 64'(0));
        checkOutput("mid_rst_valid", 64'(res_valid), 64'(0));
        checkOutput("mid_rst_data", 64'(res_data), 64'(0));
        checkOutput("mid_rst_cycles", 64'(res_cycles), 64'(0));
        checkOutput("mid_rst_done", 64'(done), 64'(0));

        // clean run after reset with the decreasing sequence 5,7,6
        applyStimulus(1, 0, 32'd5, 0);
        tick();
        applyStimulus(0, 0, 32'd5, 0);
        tick();
        applyStimulus(0, 0, 32'd7, 0);
        tick();
        applyStimulus(0, 0, 32'd6, 0);
        checkOutput("mono_before", 64'(mono_err), 64'(0));
        tick();
        applyStimulus(0, 1, 32'd6, 0);
        checkOutput("mono_raised", 64'(mono_err), 64'(mono_expect));
        sb.push_back('{data: 32'd6, cycles: 32'd8});
        tick();
        collectResult("mono_run", 4);
        checkOutput("mono_held_present", 64'(mono_err), 64'(mono_expect));
        applyStimulus(0, 1, 32'd6, 1);
        tick();
        applyStimulus(0, 0, 32'd6, 0);
        checkOutput("mono_run_done", 64'(done), 64'(1));
        checkOutput("mono_held_done", 64'(mono_err), 64'(mono_expect));

        // restart with non-decreasing 5,5,9: flag cleared and stays clear
        applyStimulus(1, 0, 32'd5, 0);
        tick();
        checkOutput("mono_cleared", 64'(mono_err), 64'(0));
        applyStimulus(0, 0, 32'd5, 0);
        tick();
        applyStimulus(0, 0, 32'd5, 0);
        tick();
        applyStimulus(0, 1, 32'd9, 0);
        sb.push_back('{data: 32'd9, cycles: 32'd7});
        tick();
        applyStimulus(0, 1, 32'd9, 1);
        collectResult("flat_run", 4);
        checkOutput("flat_mono", 64'(mono_err), 64'(0));
        tick();
        applyStimulus(0, 0, 32'd9, 0);
        checkOutput("flat_done", 64'(done), 64'(1));
        checkOutput("sb_empty", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
